// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared state encoding and default parameters for iter_mac_ctrl
package mac_ctrl_pkg;
  localparam int N_TERMS_D = 8;
  localparam int MUL_LAT_D = 1;
  localparam int CNT_W_D = 8;
  localparam int LAT_W = 4;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MUL  = 3'd2,
    S_ADD  = 3'd3,
    S_LD   = 3'd4,
    S_FIN  = 3'd5
  } state_t;
endpackage

// File: rtl/iter_mac_ctrl_if.sv
// iter_mac_ctrl_if: run request inputs and datapath control outputs of iter_mac_ctrl
//   master: drives start/abort/n_terms, observes controls
//   slave : the controller, drives ldX..done and term_idx
interface iter_mac_ctrl_if #(parameter int CNT_W = 8);
  logic start;
  logic abort;
  logic [CNT_W-1:0] n_terms;
  logic ldX;
  logic initTmp;
  logic mulEn;
  logic selTmp;
  logic ldTmp;
  logic ldCoef;
  logic [CNT_W-1:0] term_idx;
  logic busy;
  logic done;
  modport master (
    output start, abort, n_terms,
    input  ldX, initTmp, mulEn, selTmp, ldTmp, ldCoef, term_idx, busy, done
  );
  modport slave (
    input  start, abort, n_terms,
    output ldX, initTmp, mulEn, selTmp, ldTmp, ldCoef, term_idx, busy, done
  );
endinterface

// File: rtl/iter_mac_ctrl_lat_counter.sv
// lat_counter: multiplier wait counter, reloads on i_load, counts down on i_en
//   i_load/i_val: preload value, i_en: decrement, o_tc: count reached zero
module lat_counter
  import mac_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [LAT_W-1:0] i_val,
  output logic             o_tc
);
  logic [LAT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - LAT_W'(1);
  assign o_tc = r_cnt == '0;
endmodule

// File: rtl/iter_mac_ctrl.sv
// iter_mac_ctrl: sequencer for an iterative multiply-accumulate datapath
//   clk/rst: clock, asynchronous active-high reset
//   bus    : start/abort/n_terms in, ldX/initTmp/mulEn/selTmp/ldTmp/ldCoef/term_idx/busy/done out
module iter_mac_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_D,
  parameter int MUL_LAT = MUL_LAT_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic clk,
  input logic rst,
  iter_mac_ctrl_if.slave bus
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_term_idx, r_n_lat, w_n_clamp;
  logic w_tc, w_last;
  assign w_n_clamp = bus.n_terms > CNT_W'(N_TERMS) ? CNT_W'(N_TERMS) : bus.n_terms;
  assign w_last = r_term_idx + CNT_W'(1) == r_n_lat;
  // counter is held preloaded outside MUL so every MUL entry starts a fresh wait
  lat_counter u_lat (
    .clk,
    .rst,
    .i_load(r_state != S_MUL),
    .i_en(r_state == S_MUL),
    .i_val(LAT_W'(MUL_LAT - 1)),
    .o_tc(w_tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // abort overrides every transition, including start in IDLE
  always_comb begin
    w_next = S_IDLE;
    if (!bus.abort)
      case (r_state)
        S_IDLE:  w_next = bus.start ? S_INIT : S_IDLE;
        S_INIT:  w_next = w_n_clamp == '0 ? S_FIN : S_MUL;
        S_MUL:   w_next = w_tc ? S_ADD : S_MUL;
        S_ADD:   w_next = S_LD;
        S_LD:    w_next = w_last ? S_FIN : S_MUL;
        default: w_next = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_term_idx <= '0;
      r_n_lat <= '0;
    end else if (!bus.abort) begin
      if (r_state == S_INIT) begin
        r_term_idx <= '0;
        r_n_lat <= w_n_clamp;
      end else if (r_state == S_LD && !w_last) r_term_idx <= r_term_idx + CNT_W'(1);
    end
  // ldTmp and done are suppressed while abort is high so a cancelled run commits nothing
  always_comb begin
    bus.ldX = r_state == S_INIT;
    bus.initTmp = r_state == S_INIT;
    bus.mulEn = r_state == S_MUL;
    bus.selTmp = r_state == S_ADD;
    bus.ldTmp = r_state == S_ADD && !bus.abort;
    bus.ldCoef = r_state == S_LD;
    bus.busy = r_state != S_IDLE;
    bus.done = r_state == S_FIN && !bus.abort;
  end
  assign bus.term_idx = r_term_idx;
endmodule

// File: tb/tb_iter_mac_ctrl.sv
// tb_iter_mac_ctrl: two controllers (MUL_LAT 1 and 3) on shared stimulus against a timeline model
module tb_iter_mac_ctrl;
  localparam int LAT [2] = '{1, 3};
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [7:0] n_terms = 0;
  int cyc = 0, n_vec = 0, n_miss = 0;
  iter_mac_ctrl_if #(.CNT_W(8)) b1 ();
  iter_mac_ctrl_if #(.CNT_W(8)) b3 ();
  assign b1.start = start;
  assign b1.abort = abort;
  assign b1.n_terms = n_terms;
  assign b3.start = start;
  assign b3.abort = abort;
  assign b3.n_terms = n_terms;
  iter_mac_ctrl #(.N_TERMS(8), .MUL_LAT(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  iter_mac_ctrl #(.N_TERMS(8), .MUL_LAT(3), .CNT_W(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  logic [7:0] af [2];
  logic [7:0] ai [2];
  assign af[0] = {b1.ldX, b1.initTmp, b1.mulEn, b1.selTmp, b1.ldTmp, b1.ldCoef, b1.busy, b1.done};
  assign af[1] = {b3.ldX, b3.initTmp, b3.mulEn, b3.selTmp, b3.ldTmp, b3.ldCoef, b3.busy, b3.done};
  assign ai[0] = b1.term_idx;
  assign ai[1] = b3.term_idx;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // model: a run is a position p counted in edges since INIT; each term occupies LAT+2 slots
  bit act [2];
  int p [2], n [2], xidx [2];
  always @(posedge clk or posedge rst)
    for (int d = 0; d < 2; d++)
      if (rst) begin
        act[d] <= 0;
        p[d] <= 0;
        n[d] <= 0;
        xidx[d] <= 0;
      end else if (!act[d]) begin
        if (start && !abort) begin
          act[d] <= 1;
          p[d] <= 0;
          n[d] <= int'(n_terms) > 8 ? 8 : int'(n_terms);
        end
      end else if (abort) act[d] <= 0;
      else if (p[d] == 1 + n[d] * (LAT[d] + 2)) act[d] <= 0;
      else begin
        p[d] <= p[d] + 1;
        xidx[d] <= (p[d] + 1 == 1 + n[d] * (LAT[d] + 2)) ? (n[d] == 0 ? 0 : n[d] - 1) : p[d] / (LAT[d] + 2);
      end
  function automatic logic [7:0] exp_flags(input int d);
    int fin, r;
    logic [7:0] f;
    f = '0;
    if (act[d]) begin
      fin = 1 + n[d] * (LAT[d] + 2);
      f[1] = 1;
      if (p[d] == 0) f[7:6] = 2'b11;
      else if (p[d] == fin) f[0] = !abort;
      else begin
        r = (p[d] - 1) % (LAT[d] + 2);
        if (r < LAT[d]) f[5] = 1;
        else if (r == LAT[d]) begin
          f[4] = 1;
          f[3] = !abort;
        end else f[2] = 1;
      end
    end
    return f;
  endfunction
  always @(negedge clk)
    if (!rst)
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if ({af[d], ai[d]} !== {exp_flags(d), 8'(xidx[d])}) begin
          n_miss++;
          $display("FAIL cycle dut%0d at cyc %0d: flags/idx got %b/%0d want %b/%0d", d, cyc, af[d], ai[d], exp_flags(d), xidx[d]);
        end
      end
  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic run(input int nt, input int e1, input int e3, input int lt, input int mu3);
    int s, d1, d3, lt1, lt3, lc1, m3, bz1;
    d1 = -1; d3 = -1; lt1 = 0; lt3 = 0; lc1 = 0; m3 = 0; bz1 = 0;
    @(negedge clk);
    #1 start = 1;
    n_terms = 8'(nt);
    s = cyc + 1;
    for (int i = 0; i < 200 && !(d1 >= 0 && d3 >= 0); i++) begin
      @(negedge clk);
      if (b1.done && d1 < 0) d1 = cyc - s;
      if (b3.done && d3 < 0) d3 = cyc - s;
      if (b1.ldTmp) lt1++;
      if (b3.ldTmp) lt3++;
      if (b3.mulEn) m3++;
      if (b1.busy) bz1++;
      if (b1.ldCoef) begin
        chk($sformatf("n%0d_idx_at_ldcoef", nt), int'(b1.term_idx), lc1);
        lc1++;
      end
      #1;
      if (i == 0) start = 0;
      if (i == 1) n_terms = ~n_terms;
    end
    chk($sformatf("n%0d_done_edge_lat1", nt), d1, e1);
    chk($sformatf("n%0d_done_edge_lat3", nt), d3, e3);
    chk($sformatf("n%0d_ldtmp_lat1", nt), lt1, lt);
    chk($sformatf("n%0d_ldtmp_lat3", nt), lt3, lt);
    chk($sformatf("n%0d_ldcoef_lat1", nt), lc1, lt);
    chk($sformatf("n%0d_mulen_lat3", nt), m3, mu3);
    chk($sformatf("n%0d_busy_cycles_lat1", nt), bz1, e1 + 1);
    @(negedge clk);
  endtask
  initial begin
    int s, dd;
    int q[$];
    repeat (2) @(negedge clk);
    chk("reset_flags_lat1", int'(af[0]), 0);
    chk("reset_flags_lat3", int'(af[1]), 0);
    chk("reset_idx_lat1", int'(ai[0]), 0);
    rst = 0;
    run(3, 10, 16, 3, 9);
    run(0, 1, 1, 0, 0);
    run(12, 25, 41, 8, 24);
    run(2, 7, 11, 2, 6);
    @(negedge clk);
    #1 start = 1;
    n_terms = 4;
    @(negedge clk);
    #1 start = 0;
    repeat (4) @(negedge clk);
    #1 abort = 1;
    #1 chk("abort_ldtmp_gated", int'(b3.ldTmp), 0);
    chk("abort_selTmp_lat3", int'(b3.selTmp), 1);
    chk("abort_mulen_lat1", int'(b1.mulEn), 1);
    @(negedge clk);
    chk("abort_busy_lat1", int'(b1.busy), 0);
    chk("abort_busy_lat3", int'(b3.busy), 0);
    #1 abort = 0;
    @(negedge clk);
    #1 start = 1;
    abort = 1;
    @(negedge clk);
    chk("start_abort_idle_lat1", int'(b1.busy), 0);
    chk("start_abort_idle_lat3", int'(b3.busy), 0);
    #1 start = 0;
    abort = 0;
    run(3, 10, 16, 3, 9);
    @(negedge clk);
    #1 start = 1;
    n_terms = 3;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b1.selTmp) break;
    end
    chk("rst_reached_add", int'(b1.selTmp), 1);
    #1 rst = 1;
    #1 chk("rst_async_flags_lat1", int'(af[0]), 0);
    chk("rst_async_flags_lat3", int'(af[1]), 0);
    chk("rst_async_idx_lat1", int'(ai[0]), 0);
    @(negedge clk);
    #1 rst = 0;
    s = cyc + 1;
    dd = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b1.ldX) q.push_back(cyc - s);
      if (b1.done && dd < 0) dd = cyc - s;
    end
    chk("b2b_init_count", q.size(), 3);
    chk("b2b_first_init", q.size() > 0 ? q[0] : -1, 0);
    chk("b2b_done_edge", dd, 10);
    chk("b2b_second_init", q.size() > 1 ? q[1] : -1, 12);
    #1 start = 0;
    repeat (50) @(negedge clk);
    chk("final_idle_lat3", int'(b3.busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
